// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate decoder with a small output FIFO.
// Decodes on entry; the head carries imm, format, illegal flag and tag.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [31:0]                data_i,
  input  logic [TAG_W-1:0]           tag_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [XLEN-1:0]            data_o,
  output logic [2:0]                 fmt_o,
  output logic                       illegal_o,
  output logic [TAG_W-1:0]           tag_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam bit RV64  = (XLEN == 64);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C = PTR_W'(DEPTH-1);

  typedef enum logic [2:0] {
    F_NONE  = 3'd0,
    F_I     = 3'd1,
    F_SHIFT = 3'd2,
    F_S     = 3'd3,
    F_B     = 3'd4,
    F_U     = 3'd5,
    F_J     = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [6:0] op;
  logic [2:0] f3;
  assign op = data_i[6:0];
  assign f3 = data_i[14:12];

  logic [XLEN-1:0] imm_i, imm_sh, imm_s;
  logic [XLEN-1:0] imm_b, imm_u, imm_j;

  assign imm_i = {{(XLEN-12){data_i[31]}}, data_i[31:20]};
  assign imm_sh = RV64
    ? {{(XLEN-6){1'b0}}, data_i[25:20]}
    : {{(XLEN-5){1'b0}}, data_i[24:20]};
  assign imm_s = {{(XLEN-12){data_i[31]}},
                  data_i[31:25], data_i[11:7]};
  assign imm_b = {{(XLEN-13){data_i[31]}},
                  data_i[31], data_i[7],
                  data_i[30:25], data_i[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){data_i[31]}},
                  data_i[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){data_i[31]}},
                  data_i[31], data_i[19:12],
                  data_i[20], data_i[30:21], 1'b0};

  // RV64 shamt eats bit 25, so the funct field shrinks to six bits
  logic up_zero, up_sra;
  assign up_zero = RV64 ? (data_i[31:26] == 6'b0)
                        : (data_i[31:25] == 7'b0);
  assign up_sra  = RV64 ? (data_i[31:26] == 6'b010000)
                        : (data_i[31:25] == 7'b0100000);

  logic is_opimm, is_load, is_jalr, is_store;
  logic is_br, is_u, is_jal, is_none;
  assign is_opimm = (op == 7'b0010011);
  assign is_load  = (op == 7'b0000011);
  assign is_jalr  = (op == 7'b1100111);
  assign is_store = (op == 7'b0100011);
  assign is_br    = (op == 7'b1100011);
  assign is_u     = (op == 7'b0110111) |
                    (op == 7'b0010111);
  assign is_jal   = (op == 7'b1101111);
  assign is_none  = (op == 7'b0110011) |
                    (op == 7'b0001111) |
                    (op == 7'b1110011);

  logic ld_ok, st_ok;
  assign ld_ok = (f3 == 3'b000) | (f3 == 3'b001) |
                 (f3 == 3'b010) | (f3 == 3'b100) |
                 (f3 == 3'b101) |
                 (RV64 & ((f3 == 3'b011) |
                          (f3 == 3'b110)));
  assign st_ok = (f3 == 3'b000) | (f3 == 3'b001) |
                 (f3 == 3'b010) |
                 (RV64 & (f3 == 3'b011));

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_ill;

  always_comb begin
    dec_imm = '0;
    dec_fmt = F_NONE;
    dec_ill = 1'b1;
    unique case (1'b1)
      is_opimm: begin
        if (f3 == 3'b001) begin
          if (up_zero) begin
            dec_imm = imm_sh;
            dec_fmt = F_SHIFT;
            dec_ill = 1'b0;
          end
        end else if (f3 == 3'b101) begin
          if (up_zero | up_sra) begin
            dec_imm = imm_sh;
            dec_fmt = F_SHIFT;
            dec_ill = 1'b0;
          end
        end else begin
          dec_imm = imm_i;
          dec_fmt = F_I;
          dec_ill = 1'b0;
        end
      end
      is_load: begin
        if (ld_ok) begin
          dec_imm = imm_i;
          dec_fmt = F_I;
          dec_ill = 1'b0;
        end
      end
      is_jalr: begin
        if (f3 == 3'b000) begin
          dec_imm = imm_i;
          dec_fmt = F_I;
          dec_ill = 1'b0;
        end
      end
      is_store: begin
        if (st_ok) begin
          dec_imm = imm_s;
          dec_fmt = F_S;
          dec_ill = 1'b0;
        end
      end
      is_br: begin
        if ((f3 != 3'b010) && (f3 != 3'b011)) begin
          dec_imm = imm_b;
          dec_fmt = F_B;
          dec_ill = 1'b0;
        end
      end
      is_u: begin
        dec_imm = imm_u;
        dec_fmt = F_U;
        dec_ill = 1'b0;
      end
      is_jal: begin
        dec_imm = imm_j;
        dec_fmt = F_J;
        dec_ill = 1'b0;
      end
      is_none: begin
        dec_ill = 1'b0;
      end
      default: ;
    endcase
  end

  entry_t           mem_q [DEPTH];
  entry_t           new_e, head;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign new_e = '{imm: dec_imm, fmt: dec_fmt,
                   ill: dec_ill, tag: tag_i};

  assign ready_o = !rst_i & (count_q < FULL_C);
  assign valid_o = !rst_i & (count_q != '0);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push)
      wptr_d = (wptr_q == LAST_C) ? '0 : wptr_q + 1'b1;
    if (pop)
      rptr_d = (rptr_q == LAST_C) ? '0 : rptr_q + 1'b1;
    if (push & !pop)
      count_d = count_q + 1'b1;
    else if (pop & !push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // payload needs no reset: count_q gates every read
  always_ff @(posedge clk_i) begin
    if (push)
      mem_q[wptr_q] <= new_e;
  end

  assign head      = mem_q[rptr_q];
  assign data_o    = valid_o ? head.imm : '0;
  assign fmt_o     = valid_o ? head.fmt : 3'b0;
  assign illegal_o = valid_o & head.ill;
  assign tag_o     = valid_o ? head.tag : '0;
  assign count_o   = rst_i ? '0 : count_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: RV32 FIFO/decode and RV64 decode.
// Expected values are hand-decoded from the instruction encodings.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_i, rdy_o, v_o, rdy_i, ill_o;
  logic [31:0] d_i, t_i, d_o, t_o;
  logic [2:0]  f_o;
  logic [1:0]  cnt_o;

  logic        v64_i, rdy64_o, v64_o, rdy64_i, ill64_o;
  logic [31:0] d64_i, t64_i, t64_o;
  logic [63:0] d64_o;
  logic [2:0]  f64_o;
  logic [1:0]  cnt64_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(32)) u32 (
    .clk_i(clk), .rst_i(rst),
    .valid_i(v_i), .ready_o(rdy_o),
    .data_i(d_i), .tag_i(t_i),
    .valid_o(v_o), .ready_i(rdy_i),
    .data_o(d_o), .fmt_o(f_o),
    .illegal_o(ill_o), .tag_o(t_o),
    .count_o(cnt_o)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(32)) u64 (
    .clk_i(clk), .rst_i(rst),
    .valid_i(v64_i), .ready_o(rdy64_o),
    .data_i(d64_i), .tag_i(t64_i),
    .valid_o(v64_o), .ready_i(rdy64_i),
    .data_o(d64_o), .fmt_o(f64_o),
    .illegal_o(ill64_o), .tag_o(t64_o),
    .count_o(cnt64_o)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] SV [4] = '{
    32'hFE112E23, 32'hFE000CE3,
    32'h123452B7, 32'h4030D093};
  localparam logic [31:0] SD [4] = '{
    32'hFFFFFFFC, 32'hFFFFFFF8,
    32'h12345000, 32'h00000003};
  localparam logic [2:0] SF [4] = '{
    3'd3, 3'd4, 3'd5, 3'd2};

  localparam logic [31:0] IV [4] = '{
    32'h0000007F, 32'h02009093,
    32'h00001013, 32'h0000B083};
  localparam logic IL [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [2:0] IF3 [4] = '{
    3'd0, 3'd0, 3'd2, 3'd0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    v_i = 1'b0; rdy_i = 1'b1;
    d_i = '0;   t_i = '0;
    v64_i = 1'b0; rdy64_i = 1'b1;
    d64_i = '0;   t64_i = '0;
    tick; tick;
    chk("rst_valid", 64'(v_o), 64'd0);
    chk("rst_ready", 64'(rdy_o), 64'd0);
    chk("rst_count", 64'(cnt_o), 64'd0);
    chk("rst_data", 64'(d_o), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(rdy_o), 64'd1);
    chk("post_rst_valid", 64'(v_o), 64'd0);

    v_i = 1'b1; d_i = 32'hFFF00093; t_i = 32'h100;
    tick;
    v_i = 1'b0;
    chk("addi_valid", 64'(v_o), 64'd1);
    chk("addi_data", 64'(d_o), 64'hFFFFFFFF);
    chk("addi_fmt", 64'(f_o), 64'd1);
    chk("addi_ill", 64'(ill_o), 64'd0);
    chk("addi_tag", 64'(t_o), 64'h100);
    chk("addi_count", 64'(cnt_o), 64'd1);

    for (int i = 0; i < 4; i++) begin
      v_i = 1'b1; d_i = SV[i]; t_i = 32'h200 + 4 * i;
      tick;
      chk($sformatf("strm%0d_data", i), 64'(d_o), 64'(SD[i]));
      chk($sformatf("strm%0d_fmt", i), 64'(f_o), 64'(SF[i]));
      chk($sformatf("strm%0d_tag", i), 64'(t_o),
          64'(32'h200 + 4 * i));
      chk($sformatf("strm%0d_cnt", i), 64'(cnt_o), 64'd1);
    end
    v_i = 1'b0;
    tick;
    chk("drain_valid", 64'(v_o), 64'd0);
    chk("drain_count", 64'(cnt_o), 64'd0);
    chk("drain_data", 64'(d_o), 64'd0);

    for (int i = 0; i < 4; i++) begin
      v_i = 1'b1; d_i = IV[i]; t_i = 32'h280;
      tick;
      chk($sformatf("ill%0d_ill", i), 64'(ill_o), 64'(IL[i]));
      chk($sformatf("ill%0d_fmt", i), 64'(f_o), 64'(IF3[i]));
      chk($sformatf("ill%0d_data", i), 64'(d_o), 64'd0);
    end
    v_i = 1'b0;
    tick;

    rdy_i = 1'b0; v_i = 1'b1;
    d_i = 32'h00500093; t_i = 32'h300;
    tick;
    d_i = 32'h00A00093; t_i = 32'h304;
    tick;
    chk("full_ready", 64'(rdy_o), 64'd0);
    chk("full_count", 64'(cnt_o), 64'd2);
    chk("full_data", 64'(d_o), 64'd5);
    chk("full_tag", 64'(t_o), 64'h300);
    d_i = 32'h00F00093; t_i = 32'h308;
    tick;
    chk("hold_data", 64'(d_o), 64'd5);
    chk("hold_tag", 64'(t_o), 64'h300);
    chk("hold_count", 64'(cnt_o), 64'd2);
    rdy_i = 1'b1;
    tick;
    chk("popfull_count", 64'(cnt_o), 64'd1);
    chk("popfull_ready", 64'(rdy_o), 64'd1);
    chk("popfull_data", 64'(d_o), 64'd10);
    chk("popfull_tag", 64'(t_o), 64'h304);
    tick;
    chk("wrap_data", 64'(d_o), 64'd15);
    chk("wrap_tag", 64'(t_o), 64'h308);
    chk("wrap_count", 64'(cnt_o), 64'd1);
    rdy_i = 1'b0;
    d_i = 32'h01400093; t_i = 32'h30C;
    tick;
    v_i = 1'b0;
    chk("refill_count", 64'(cnt_o), 64'd2);

    v_i = 1'b1; d_i = 32'h00100093; t_i = 32'h310;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(v_o), 64'd0);
    chk("midrst_ready", 64'(rdy_o), 64'd0);
    chk("midrst_tag", 64'(t_o), 64'd0);
    tick;
    rst = 1'b0; v_i = 1'b0;
    #1;
    chk("after_rst_count", 64'(cnt_o), 64'd0);
    chk("after_rst_ready", 64'(rdy_o), 64'd1);
    chk("after_rst_valid", 64'(v_o), 64'd0);
    rdy_i = 1'b1;
    tick;
    chk("no_stale_valid", 64'(v_o), 64'd0);
    chk("no_stale_count", 64'(cnt_o), 64'd0);

    v64_i = 1'b1; d64_i = 32'h0010D093; t64_i = 32'h400;
    tick;
    chk("rv64_srli_data", d64_o, 64'h1);
    chk("rv64_srli_fmt", 64'(f64_o), 64'd2);
    chk("rv64_srli_tag", 64'(t64_o), 64'h400);
    d64_i = 32'h8000006F; t64_i = 32'h404;
    tick;
    chk("rv64_jal_data", d64_o, 64'hFFFFFFFFFFF00000);
    chk("rv64_jal_fmt", 64'(f64_o), 64'd6);
    d64_i = 32'h02009093;
    tick;
    chk("rv64_sh32_data", d64_o, 64'd32);
    chk("rv64_sh32_ill", 64'(ill64_o), 64'd0);
    d64_i = 32'h0000B083;
    tick;
    chk("rv64_ld_fmt", 64'(f64_o), 64'd1);
    chk("rv64_ld_ill", 64'(ill64_o), 64'd0);
    v64_i = 1'b0;
    tick;
    chk("rv64_drain", 64'(v64_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered successor to the single-cycle immediate generator.
- Decodes every RV32I/RV64I immediate format (I, shift-immediate, S, B, U, J) into an XLEN-wide value, plus a format code and an illegal flag.
- Results pass through a DEPTH-entry FIFO with valid/ready handshakes, so the decode stage decouples from a stalling execute stage.
- Sits between the IF/ID register and the ID/EX register; a tag (normally the PC) travels with each entry.

Parameters:
- XLEN, 32, output width; legal values 32 or 64. Selects RV32/RV64 shamt and funct3 legality rules.
- DEPTH, 2, FIFO entries; legal range 2..8.
- TAG_W, 32, width of the sideband tag carried with each instruction.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  data_i/tag_i hold an instruction.
- ready_o  out  1  block can accept an instruction this cycle.
- data_i  in  32  instruction word.
- tag_i  in  TAG_W  sideband, e.g. PC.
- valid_o  out  1  FIFO head is valid.
- ready_i  in  1  consumer accepts the head this cycle.
- data_o  out  XLEN  decoded immediate at the head.
- fmt_o  out  3  head format: 0 NONE, 1 I, 2 SHIFT, 3 S, 4 B, 5 U, 6 J.
- illegal_o  out  1  head instruction is unrecognised.
- tag_o  out  TAG_W  tag at the head.
- count_o  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset:
  - Pointers and count are cleared; entries are invalidated.
  - While rst_i=1: valid_o=0, ready_o=0, count_o=0, and data_o/fmt_o/illegal_o/tag_o=0.
  - Reset mid-operation flushes all entries. A handshake coincident with rst_i=1 is discarded.
- Push and pop:
  - Push occurs when valid_i & ready_o. Decode is combinational on data_i and is written into the tail entry at the clock edge.
  - Pop occurs when valid_o & ready_i.
  - ready_o = !rst_i & (count < DEPTH). It depends only on registered state; there is no combinational path from ready_i to ready_o.
  - When full, no push occurs even if a pop happens in the same cycle.
  - Push and pop in the same cycle (not full, not empty): count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Latency: an entry pushed at edge N is visible at the head on cycle N+1 if the FIFO was empty. Throughput is 1 instruction/cycle when ready_i is held at 1.
- Head outputs:
  - valid_o = (count != 0).
  - When empty, data_o, fmt_o, illegal_o and tag_o read 0.
  - While valid_o=1 and ready_i=0, the head outputs are held stable.
- Decode rules (op = data_i[6:0], f3 = data_i[14:12]); "sext" means sign-extend to XLEN from data_i[31]:
  - op 0010011 with f3 in {000,010,011,100,110,111}: format I, sext(data_i[31:20]).
  - op 0010011 with f3=001: format SHIFT, zero-extended shamt. Requires data_i[31:25]=0 (RV32) or data_i[31:26]=0 (RV64); otherwise illegal.
  - op 0010011 with f3=101: format SHIFT. Same rule as f3=001, except the upper field may also equal 0100000 (RV32) or 010000 (RV64).
  - shamt width is 5 bits (data_i[24:20]) for RV32 and 6 bits (data_i[25:20]) for RV64.
  - op 0000011 (load) with f3 in {000,001,010,100,101}: format I. RV64 additionally allows {011,110}.
  - op 1100111 (JALR) with f3=000: format I.
  - op 0100011 (store) with f3 in {000,001,010}: format S, sext({data_i[31:25], data_i[11:7]}). RV64 additionally allows 011.
  - op 1100011 (branch) with f3 not in {010,011}: format B, sext({data_i[31], data_i[7], data_i[30:25], data_i[11:8], 1'b0}).
  - op 0110111 or 0010111 (LUI/AUIPC): format U, sext({data_i[31:12], 12'b0}).
  - op 1101111 (JAL): format J, sext({data_i[31], data_i[19:12], data_i[20], data_i[30:21], 1'b0}).
  - op 0110011, 0001111 or 1110011: format NONE, data 0, illegal=0.
  - Anything else, including a disallowed f3, a bad shift upper field, or data_i[1:0] != 11: illegal=1, format NONE, data 0.
- count_o always equals pushes minus pops since reset and never exceeds DEPTH.

Test Plan:
- Reset, then push 0xFFF00093 (addi x1,x0,-1) with ready_i=1 -> next cycle: valid_o=1, data_o=0xFFFFFFFF, fmt_o=1, illegal_o=0, tag_o=tag_i.
- Back-to-back pushes of 0xFE112E23, 0xFE000CE3, 0x123452B7, 0x4030D093, with ready_i=1 -> consecutive outputs:
  - 0xFFFFFFFC / S
  - 0xFFFFFFF8 / B
  - 0x12345000 / U
  - 0x00000003 / SHIFT
- Push 0x0000007F, 0x02009093 (slli with bad funct7) and 0x00000013 with f3 forced to 001 and funct7=0 -> outputs in order:
  - illegal_o=1, data_o=0, fmt_o=0
  - illegal_o=1, data_o=0, fmt_o=0
  - legal SHIFT
- ready_i=0 with continuous valid_i:
  - After DEPTH pushes, ready_o=0 and count_o=DEPTH.
  - Head outputs stay stable.
  - Raising ready_i with valid_i=1 while full -> one pop and no push that cycle; ready_o=1 on the next cycle.
- Assert rst_i for one cycle while count_o=2 -> that cycle: valid_o=0, ready_o=0. Next cycle: count_o=0, ready_o=1, and no stale entry emerges.
- XLEN=64: 0x0010D093 (srli x1,x1,1) -> data_o=0x0000000000000001; 0x8000006F (JAL with negative offset) -> data_o=0xFFFFFFFFFFF00000, fmt_o=6.
